// File: rtl/ln_1_block_16.sv
// rtl/ln_1_block_16.sv - natural log of an unsigned 8.8 operand, returned as signed 1.7.8
// Leading-one normalisation, then one ln(1+2^-k) shift-add step per cycle, valid/ready both sides.
module ln_1_block_16 #(
  parameter int data_size = 16,
  parameter int frac_bits = 8,
  parameter int iters     = 12
) (
  input  logic                 clock_i,
  input  logic                 reset_n_i,
  input  logic [data_size-1:0] ln_data_i,
  input  logic                 ln_data_valid_i,
  output logic                 ln_data_ready_o,
  input  logic                 ln_last_i,
  output logic [data_size-1:0] ln_data_o,
  output logic                 ln_data_valid_o,
  input  logic                 ln_data_ready_i,
  output logic                 ln_last_o,
  output logic                 ln_done_o
);

  localparam logic        [3:0]  ITERS_K = 4'(iters);
  localparam logic signed [23:0] LN2     = 24'sd45426;

  typedef enum logic [1:0] {IDLE, NORM, ITER, DONE} state_t;

  state_t             state_q, state_d;
  logic        [15:0] x_q;
  logic               last_q;
  logic               zero_q;
  logic        [17:0] m_q;
  logic        [19:0] s_q;
  logic signed [5:0]  exp_q;
  logic        [3:0]  k_q;

  logic        [3:0]  lead_p;
  logic        [17:0] t_val;
  logic        [15:0] lut_val;
  logic signed [23:0] r_full;
  logic signed [23:0] r_rnd;
  logic        [15:0] res_val;
  logic               accept;
  logic               handshake;

  function automatic logic [3:0] lead_one(input logic [15:0] v);
    lead_one = '0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) lead_one = 4'(i);
    end
  endfunction

  // ln(1+2^-k) in Q0.16
  function automatic logic [15:0] lut_ln(input logic [3:0] k);
    case (k)
      4'd1:    lut_ln = 16'd26573;
      4'd2:    lut_ln = 16'd14624;
      4'd3:    lut_ln = 16'd7719;
      4'd4:    lut_ln = 16'd3973;
      4'd5:    lut_ln = 16'd2017;
      4'd6:    lut_ln = 16'd1016;
      4'd7:    lut_ln = 16'd510;
      4'd8:    lut_ln = 16'd255;
      4'd9:    lut_ln = 16'd128;
      4'd10:   lut_ln = 16'd64;
      4'd11:   lut_ln = 16'd32;
      4'd12:   lut_ln = 16'd16;
      4'd13:   lut_ln = 16'd8;
      4'd14:   lut_ln = 16'd4;
      4'd15:   lut_ln = 16'd2;
      default: lut_ln = 16'd0;
    endcase
  endfunction

  always_comb begin
    lead_p  = lead_one(x_q);
    t_val   = m_q + (m_q >> k_q);
    lut_val = lut_ln(k_q);
    // M*prod(1+2^-k) converges on 2, so ln(M) = ln2 - S
    r_full  = $signed({{18{exp_q[5]}}, exp_q}) * LN2 + LN2 - $signed({4'b0, s_q});
    r_rnd   = (r_full + 24'sd128) >>> 8;
    if (zero_q)                  res_val = 16'h8000;
    else if (r_rnd > 24'sd32767)  res_val = 16'h7FFF;
    else if (r_rnd < -24'sd32768) res_val = 16'h8000;
    else                          res_val = r_rnd[15:0];
  end

  assign accept    = ln_data_valid_i && ln_data_ready_o;
  assign handshake = ln_data_valid_o && ln_data_ready_i;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = NORM;
      NORM:    state_d = ITER;
      ITER:    if (k_q == ITERS_K) state_d = DONE;
      DONE:    if (handshake) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ln_data_ready_o = reset_n_i && (state_q == IDLE);
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      x_q             <= '0;
      last_q          <= 1'b0;
      zero_q          <= 1'b0;
      m_q             <= '0;
      s_q             <= '0;
      exp_q           <= '0;
      k_q             <= '0;
      ln_data_o       <= '0;
      ln_data_valid_o <= 1'b0;
      ln_last_o       <= 1'b0;
      ln_done_o       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            x_q    <= ln_data_i;
            last_q <= ln_last_i;
          end
        end
        NORM: begin
          exp_q  <= $signed({2'b00, lead_p}) - $signed(6'(frac_bits));
          m_q    <= {1'b0, x_q << (4'd15 - lead_p), 1'b0};
          s_q    <= '0;
          k_q    <= 4'd1;
          zero_q <= (x_q == 16'h0000);
        end
        ITER: begin
          if (!t_val[17]) begin
            m_q <= t_val;
            s_q <= s_q + {4'b0, lut_val};
          end
          k_q <= k_q + 4'd1;
        end
        DONE: begin
          // first DONE cycle publishes the result, later cycles wait for the sink
          if (!ln_data_valid_o) begin
            ln_data_o       <= res_val;
            ln_data_valid_o <= 1'b1;
            ln_last_o       <= last_q;
          end else if (ln_data_ready_i) begin
            ln_data_valid_o <= 1'b0;
            if (ln_last_o) ln_done_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
